uart_frame_ctrl: RTL and testbench

Receive-side frame controller placed directly after the UART byte receiver. It consumes the receiver's byte strobe, data and connection flag, and parses frames of the form 0xA5, LEN, LEN payload bytes, CHK. The payload is stored in an internal buffer. Completed frames are presented to the application through a valid/ack handshake, with a random-access read port for the payload. Malformed, stalled or interrupted frames are discarded and reported.

---
 rtl/uart_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Receive-side framer: parses A5/LEN/payload/CHK byte streams from the UART receiver into a held payload buffer.
// Frame status and errors appear one cycle after the causing byte; reads have 1-cycle latency; bytes during WAIT_ACK are dropped and flagged.
module uart_frame_ctrl #(
    parameter int unsigned CLK_PER_BIT  = 868,
    parameter int unsigned TIMEOUT_BITS = 40,
    parameter int unsigned MAX_LEN      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_recv,
    input  logic       i_conn,
    input  logic       i_frame_ack,
    input  logic [7:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_frame_valid,
    output logic [7:0] o_frame_len,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun
);

    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [23:0] TO_LAST   = 24'(CLK_PER_BIT * TIMEOUT_BITS - 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CHK   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_WAIT_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [23:0] timer_q, timer_d;

    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        valid_q, valid_d;
    logic [7:0]  frame_len_q, frame_len_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [7:0]  mem_q [MAX_LEN];

    logic in_frame;
    logic conn_lost;
    logic timed_out;
    logic abort;
    logic len_bad;
    logic wr_en;

    // Connection loss outranks timeout, which outranks any byte in the same cycle.
    assign in_frame  = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign conn_lost = in_frame && !i_conn;
    assign timed_out = in_frame && (timer_q == TO_LAST);
    assign abort     = conn_lost || timed_out;
    assign len_bad   = {1'b0, i_data} > MAX_LEN_W;
    assign wr_en     = (state_q == S_PAYLOAD) && i_recv && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HUNT;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            sum_q   <= 8'd0;
            timer_q <= 24'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        timer_d = 24'd0;
        if (in_frame && !abort && !i_recv) begin
            timer_d = timer_q + 24'd1;
        end
        case (state_q)
            S_HUNT: begin
                if (i_recv && (i_data == SYNC_BYTE)) begin
                    state_d = S_LEN;
                    sum_d   = 8'd0;
                end
            end
            S_LEN: begin
                if (abort) begin
                    state_d = S_HUNT;
                end else if (i_recv) begin
                    if (len_bad) begin
                        state_d = S_HUNT;
                    end else if (i_data == 8'd0) begin
                        len_d   = 8'd0;
                        sum_d   = 8'd0;
                        state_d = S_CHECK;
                    end else begin
                        len_d   = i_data;
                        sum_d   = i_data;
                        idx_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (abort) begin
                    state_d = S_HUNT;
                end else if (i_recv) begin
                    sum_d = sum_q + i_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_HUNT;
                end else if (i_recv) begin
                    state_d = (i_data == sum_q) ? S_WAIT_ACK : S_HUNT;
                end
            end
            S_WAIT_ACK: begin
                if (i_frame_ack) begin
                    state_d = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_comb begin
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        valid_d     = valid_q;
        frame_len_d = frame_len_q;
        overrun_d   = overrun_q;
        if (abort) begin
            err_d      = 1'b1;
            err_code_d = ERR_ABORT;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (i_recv && len_bad) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end
                end
                S_CHECK: begin
                    if (i_recv) begin
                        if (i_data == sum_q) begin
                            valid_d     = 1'b1;
                            frame_len_d = len_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CHK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    // Ack wins over a byte landing in the same cycle.
                    if (i_frame_ack) begin
                        valid_d   = 1'b0;
                        overrun_d = 1'b0;
                    end else if (i_recv) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data_d = 8'd0;
        if ({1'b0, i_rd_addr} < MAX_LEN_W) begin
            rd_data_d = mem_q[i_rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            valid_q     <= 1'b0;
            frame_len_q <= 8'd0;
            overrun_q   <= 1'b0;
            rd_data_q   <= 8'd0;
        end else begin
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            valid_q     <= valid_d;
            frame_len_q <= frame_len_d;
            overrun_q   <= overrun_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_q[AW-1:0]] <= i_data;
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_frame_valid = valid_q;
    assign o_frame_len   = frame_len_q;
    assign o_err         = err_q;
    assign o_err_code    = err_code_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: directed byte streams push expected frame/error events; a monitor pops them.
module tb_uart_frame_ctrl;

    localparam int CPB   = 10;
    localparam int TOB   = 40;
    localparam int LIMIT = CPB * TOB;
    localparam int MAXL  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_recv;
    logic       i_conn;
    logic       i_frame_ack;
    logic [7:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_frame_valid;
    logic [7:0] o_frame_len;
    logic       o_err;
    logic [1:0] o_err_code;
    logic       o_overrun;

    uart_frame_ctrl #(
        .CLK_PER_BIT (CPB),
        .TIMEOUT_BITS(TOB),
        .MAX_LEN     (MAXL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_recv       (i_recv),
        .i_conn       (i_conn),
        .i_frame_ack  (i_frame_ack),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_frame_valid(o_frame_valid),
        .o_frame_len  (o_frame_len),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic exp_frame(input logic [7:0] len);
        exp_q.push_back('{is_err: 1'b0, val: len});
    endtask

    task automatic exp_err(input logic [1:0] code);
        exp_q.push_back('{is_err: 1'b1, val: {6'd0, code}});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_data = b;
        i_recv = 1'b1;
        @(negedge clk);
        i_recv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] req, input string name);
        @(negedge clk);
        i_rd_addr = addr;
        @(posedge clk);
        #1;
        check(name, {24'd0, o_rd_data}, {24'd0, req});
    endtask

    task automatic ack();
        @(negedge clk);
        i_frame_ack = 1'b1;
        @(negedge clk);
        i_frame_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},   {31'd0, o_frame_valid}, 32'd0);
        check({tag, "_len"},     {24'd0, o_frame_len},   32'd0);
        check({tag, "_err"},     {31'd0, o_err},         32'd0);
        check({tag, "_code"},    {30'd0, o_err_code},    32'd0);
        check({tag, "_overrun"}, {31'd0, o_overrun},     32'd0);
        check({tag, "_rd_data"}, {24'd0, o_rd_data},     32'd0);
    endtask

    // Monitor: every o_err pulse and every rising o_frame_valid must match the head of the queue.
    initial begin
        logic prev_err;
        logic prev_valid;
        exp_t e;
        prev_err   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_err === 1'b1) begin
                check("err_one_cycle", {31'd0, prev_err}, 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_err actual=code%0d required=no_event", o_err_code);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_err || (o_err_code !== e.val[1:0])) begin
                        failures++;
                        $display("FAIL err_event actual=err code%0d required=%s %0d",
                                 o_err_code, e.is_err ? "err code" : "frame len", e.val);
                    end
                end
            end
            if ((o_frame_valid === 1'b1) && !prev_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame actual=len%0d required=no_event", o_frame_len);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err || (o_frame_len !== e.val)) begin
                        failures++;
                        $display("FAIL frame_event actual=frame len %0d required=%s %0d",
                                 o_frame_len, e.is_err ? "err code" : "frame len", e.val);
                    end
                end
            end
            prev_err   = (o_err === 1'b1);
            prev_valid = (o_frame_valid === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_data      = 8'd0;
        i_recv      = 1'b0;
        i_conn      = 1'b1;
        i_frame_ack = 1'b0;
        i_rd_addr   = 8'd0;
        #1;
        check_reset_values("reset");
        #11;
        rst = 1'b0;

        // Good 3-byte frame: checksum = 03+11+22+33 = 69.
        exp_frame(8'd3);
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        idle(1);
        check("t1_valid", {31'd0, o_frame_valid}, 32'd1);
        rd(8'd0, 8'h11, "t1_rd0");
        rd(8'd1, 8'h22, "t1_rd1");
        rd(8'd2, 8'h33, "t1_rd2");
        ack();
        check("t1_valid_after_ack", {31'd0, o_frame_valid}, 32'd0);

        // Bad checksum (expected 32), then an empty frame.
        exp_err(2'd2);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        idle(2);
        check("t2_valid_stays_low", {31'd0, o_frame_valid}, 32'd0);
        exp_frame(8'd0);
        send(8'hA5); send(8'h00); send(8'h00);
        idle(1);
        check("t2_len0_valid", {31'd0, o_frame_valid}, 32'd1);
        ack();

        // Length 17 exceeds the buffer; trailing bytes must be ignored.
        exp_err(2'd1);
        send(8'hA5); send(8'h11);
        send(8'h01); send(8'h02);
        idle(3);
        exp_frame(8'd1);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        idle(1);
        rd(8'd0, 8'h7E, "t3_rd0");
        rd(8'd16, 8'h00, "t3_rd_addr_max");
        rd(8'd200, 8'h00, "t3_rd_addr_far");
        ack();

        // Timeout exactly LIMIT cycles after the last accepted byte.
        exp_err(2'd3);
        send(8'hA5); send(8'h02); send(8'h10);
        idle(LIMIT - 1);
        check("t4_no_err_before_limit", {31'd0, o_err}, 32'd0);
        idle(1);
        check("t4_err_at_limit", {31'd0, o_err}, 32'd1);
        check("t4_code", {30'd0, o_err_code}, 32'd3);
        exp_frame(8'd1);
        send(8'hA5); send(8'h01); send(8'h05); send(8'h06);
        idle(1);
        rd(8'd0, 8'h05, "t4_rd0");
        ack();

        // Overrun while a frame is held: checksum = 02+AA+BB = 67.
        exp_frame(8'd2);
        send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h67);
        idle(1);
        check("t5_overrun_clear", {31'd0, o_overrun}, 32'd0);
        send(8'h55); send(8'hA5);
        check("t5_overrun_set", {31'd0, o_overrun}, 32'd1);
        check("t5_valid_held", {31'd0, o_frame_valid}, 32'd1);
        rd(8'd0, 8'hAA, "t5_rd0");
        rd(8'd1, 8'hBB, "t5_rd1");
        @(negedge clk);
        i_frame_ack = 1'b1;
        i_recv      = 1'b1;
        i_data      = 8'hA5;
        @(negedge clk);
        i_frame_ack = 1'b0;
        i_recv      = 1'b0;
        check("t5_overrun_after_ack", {31'd0, o_overrun}, 32'd0);
        check("t5_valid_after_ack", {31'd0, o_frame_valid}, 32'd0);
        // Would form a valid frame if the A5 alongside the ack had been taken as sync.
        send(8'h01); send(8'h33); send(8'h34);
        idle(2);
        check("t5_no_frame_from_ack_byte", {31'd0, o_frame_valid}, 32'd0);

        // Connection drop mid-payload.
        exp_err(2'd3);
        send(8'hA5); send(8'h03); send(8'h01);
        @(negedge clk);
        i_conn = 1'b0;
        @(negedge clk);
        i_conn = 1'b1;
        check("t6_conn_code", {30'd0, o_err_code}, 32'd3);
        idle(2);

        // Asynchronous reset mid-frame.
        send(8'hA5); send(8'h02); send(8'h01);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_mid_frame");
        #1 rst = 1'b0;
        send(8'h02); send(8'h03);
        idle(2);

        // Asynchronous reset while a frame is held with overrun set.
        exp_frame(8'd1);
        send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
        send(8'h00);
        rd(8'd0, 8'h5A, "t6_rd0");
        check("t6_overrun_pre_rst", {31'd0, o_overrun}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("rst_while_valid");
        #1 rst = 1'b0;

        exp_frame(8'd0);
        send(8'hA5); send(8'h00); send(8'h00);
        idle(1);
        check("post_rst_frame_valid", {31'd0, o_frame_valid}, 32'd1);
        ack();
        idle(5);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
